// File: rtl/otfs_frame_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// otfs_frame_fifo_ctrl_if
//   Bundles the symbol-stream, frame-output and FIFO-side signals of the OTFS
//   frame FIFO controller.
//
//   Signal groups
//     upstream stream : s_data, s_valid, s_ready
//     frame request   : frame_req (single-cycle pulse from downstream)
//     frame output    : m_data, m_valid, m_sof, m_eof (no backpressure)
//     FIFO write side : fifo_srst, fifo_din, fifo_wr_en
//     FIFO read side  : fifo_rd_en, fifo_dout, fifo_valid, fifo_empty
//     FIFO status     : fifo_full, fifo_rst_busy (wr_rst_busy | rd_rst_busy)
//
//   Modports
//     master : the controller's view (drives s_ready, m_*, fifo_* controls)
//     slave  : the surrounding system's view (sources, sink and FIFO)
// -----------------------------------------------------------------------------
interface otfs_frame_fifo_ctrl_if #(
  parameter int DATA_W = 2
);

  // Upstream symbol stream
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  // Downstream frame request
  logic              frame_req;

  // Frame output
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_sof;
  logic              m_eof;

  // FIFO primitive connections
  logic              fifo_srst;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_wr_en;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_valid;
  logic              fifo_rst_busy;

  modport master (
    input  s_data, s_valid, frame_req,
    input  fifo_dout, fifo_full, fifo_empty, fifo_valid, fifo_rst_busy,
    output s_ready,
    output m_data, m_valid, m_sof, m_eof,
    output fifo_srst, fifo_din, fifo_wr_en, fifo_rd_en
  );

  modport slave (
    output s_data, s_valid, frame_req,
    output fifo_dout, fifo_full, fifo_empty, fifo_valid, fifo_rst_busy,
    input  s_ready,
    input  m_data, m_valid, m_sof, m_eof,
    input  fifo_srst, fifo_din, fifo_wr_en, fifo_rd_en
  );

endinterface

// File: rtl/otfs_frame_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// otfs_frame_fifo_ctrl
//   Controls an external FIFO (Xilinx-style, standard read latency of one
//   cycle with a fifo_valid strobe) that buffers QAM symbols for an OTFS
//   modulator. Symbols are accepted continuously from the upstream stream;
//   on a downstream frame_req the controller waits until a whole frame is
//   buffered, then reads exactly FRAME_LEN symbols as one burst and presents
//   them on m_* with start/end-of-frame markers.
//
//   Ports
//     clk, rst_n     : sole clock (posedge) and asynchronous active-low reset
//     bus (master)   : stream, frame output and FIFO signals, see interface
//     level          : symbols currently held in the FIFO (controller's count)
//     busy           : high in every state except IDLE
//     err_underflow  : sticky, set when a read is issued against an empty FIFO
//     clr_err        : clears err_underflow on the next edge (a set wins)
//
//   FSM
//     INIT  : pulse fifo_srst for SRST_CYCLES, then wait for fifo_rst_busy=0
//     IDLE  : wait for a pending request and level >= FRAME_LEN
//     READ  : fifo_rd_en high for exactly FRAME_LEN consecutive cycles
//     DRAIN : wait for the FRAME_LEN-th fifo_valid of the burst
//     GAP   : GAP_CYCLES idle cycles between bursts
// -----------------------------------------------------------------------------
module otfs_frame_fifo_ctrl #(
  parameter int DATA_W      = 2,
  parameter int DEPTH       = 1024,
  parameter int FRAME_LEN   = 64,
  parameter int SRST_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  otfs_frame_fifo_ctrl_if.master     bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       err_underflow,
  input  logic                       clr_err
);

  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int SRST_W = $clog2(SRST_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    READ,
    DRAIN,
    GAP
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic [SRST_W-1:0]   srst_cnt_q, srst_cnt_d;
  logic                srst_q,     srst_d;
  logic [CNT_W-1:0]    rd_cnt_q,   rd_cnt_d;
  logic [CNT_W-1:0]    vld_cnt_q,  vld_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;
  logic                req_q,      req_d;
  logic [LVL_W-1:0]    level_q,    level_d;
  logic                err_q,      err_d;
  logic [CNT_W-1:0]    out_cnt_q,  out_cnt_d;
  logic [DATA_W-1:0]   m_data_q,   m_data_d;
  logic                m_valid_q,  m_valid_d;
  logic                m_sof_q,    m_sof_d;
  logic                m_eof_q,    m_eof_d;

  logic                start_frame;
  logic                rd_en;
  logic                wr_en;
  logic                s_ready;
  logic                frame_ready;
  logic                burst_done;

  // ---------------------------------------------------------------------------
  // Write side: accept whenever the FIFO has room and reset has settled.
  // level is checked as well as fifo_full because the FIFO's full flag may
  // lag our own count by a cycle or more.
  // ---------------------------------------------------------------------------
  assign s_ready = (state_q != INIT) && !bus.fifo_full && (level_q < LVL_W'(DEPTH));
  assign wr_en   = bus.s_valid && s_ready;

  // Read enable is a pure decode of the state, so an asynchronous reset
  // removes it in the same instant it forces INIT.
  assign rd_en   = (state_q == READ);

  assign frame_ready = req_q && (level_q >= LVL_W'(FRAME_LEN));

  // The last beat of a burst may be counted already (vld_cnt reached the
  // frame length) or be arriving on fifo_valid right now.
  assign burst_done  = (vld_cnt_q == CNT_W'(FRAME_LEN)) ||
                       (bus.fifo_valid && (vld_cnt_q == CNT_W'(FRAME_LEN - 1)));

  // ---------------------------------------------------------------------------
  // FSM next-state and per-state counters
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    srst_cnt_d  = srst_cnt_q;
    srst_d      = 1'b0;
    rd_cnt_d    = rd_cnt_q;
    vld_cnt_d   = vld_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    start_frame = 1'b0;

    unique case (state_q)
      INIT: begin
        // srst is registered so it rises on the first edge after reset and
        // stays high for exactly SRST_CYCLES cycles.
        if (srst_cnt_q < SRST_W'(SRST_CYCLES)) begin
          srst_d     = 1'b1;
          srst_cnt_d = srst_cnt_q + 1'b1;
        end else if (!bus.fifo_rst_busy) begin
          state_d    = IDLE;
        end
      end

      IDLE: begin
        vld_cnt_d = '0;
        if (frame_ready) begin
          state_d     = READ;
          start_frame = 1'b1;
          rd_cnt_d    = '0;
        end
      end

      READ: begin
        if (bus.fifo_valid) begin
          vld_cnt_d = vld_cnt_q + 1'b1;
        end
        if (rd_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          state_d  = DRAIN;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end

      DRAIN: begin
        if (burst_done) begin
          state_d   = GAP;
          vld_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (bus.fifo_valid) begin
          vld_cnt_d = vld_cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, level counter, underflow flag
  // ---------------------------------------------------------------------------
  always_comb begin
    // A new request is applied after the clear, so a frame_req landing on
    // the IDLE->READ edge is kept for the following frame.
    req_d = req_q;
    if (start_frame) begin
      req_d = 1'b0;
    end
    if (bus.frame_req && (state_q != INIT)) begin
      req_d = 1'b1;
    end

    level_d = level_q;
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Set is evaluated last so it beats a simultaneous clr_err.
    err_d = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (rd_en && bus.fifo_empty) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: one register after the FIFO read port. out_cnt tracks the
  // beat position within a frame independently of the FSM so the markers
  // follow the data even though it lags rd_en by two cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    m_data_d  = bus.fifo_dout;
    m_valid_d = bus.fifo_valid;
    m_sof_d   = 1'b0;
    m_eof_d   = 1'b0;
    out_cnt_d = out_cnt_q;
    if (bus.fifo_valid) begin
      m_sof_d = (out_cnt_q == '0);
      m_eof_d = (out_cnt_q == CNT_W'(FRAME_LEN - 1));
      if (out_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
        out_cnt_d = '0;
      end else begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset abandons any frame in flight; the INIT srst pulse that
  // follows flushes whatever the FIFO still holds, so level restarts at 0.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      srst_cnt_q <= '0;
      srst_q     <= 1'b0;
      rd_cnt_q   <= '0;
      vld_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      req_q      <= 1'b0;
      level_q    <= '0;
      err_q      <= 1'b0;
      out_cnt_q  <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eof_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      srst_cnt_q <= srst_cnt_d;
      srst_q     <= srst_d;
      rd_cnt_q   <= rd_cnt_d;
      vld_cnt_q  <= vld_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      req_q      <= req_d;
      level_q    <= level_d;
      err_q      <= err_d;
      out_cnt_q  <= out_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_sof_q    <= m_sof_d;
      m_eof_q    <= m_eof_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  assign bus.s_ready    = s_ready;
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_din   = bus.s_data;
  assign bus.fifo_rd_en = rd_en;
  assign bus.fifo_srst  = srst_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_sof      = m_sof_q;
  assign bus.m_eof      = m_eof_q;

  assign level          = level_q;
  assign busy           = (state_q != IDLE);
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_otfs_frame_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_otfs_frame_fifo_ctrl
//   Directed bench for otfs_frame_fifo_ctrl with FRAME_LEN=4, DEPTH=16,
//   SRST_CYCLES=4, GAP_CYCLES=2. A small behavioural FIFO (one-cycle read
//   latency with a valid strobe, flushed by fifo_srst) sits on the FIFO side.
//   Outputs are sampled on the falling edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_otfs_frame_fifo_ctrl;

  localparam int DATA_W    = 2;
  localparam int DEPTH     = 16;
  localparam int FRAME_LEN = 4;
  localparam int LVL_W     = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr_err;
  logic [LVL_W-1:0] level;
  logic             busy;
  logic             err_underflow;

  int tests = 0;
  int fails = 0;

  otfs_frame_fifo_ctrl_if #(.DATA_W(DATA_W)) bus ();

  otfs_frame_fifo_ctrl #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .FRAME_LEN   (FRAME_LEN),
    .SRST_CYCLES (4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .level         (level),
    .busy          (busy),
    .err_underflow (err_underflow),
    .clr_err       (clr_err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  int                wp  = 0;
  int                rp  = 0;
  int                cnt = 0;
  logic [DATA_W-1:0] fd_q = '0;
  logic              fv_q = 1'b0;
  logic              force_empty;

  always @(posedge clk) begin
    if (bus.fifo_srst) begin
      wp   <= 0;
      rp   <= 0;
      cnt  <= 0;
      fv_q <= 1'b0;
    end else begin
      if (bus.fifo_wr_en && cnt < DEPTH) begin
        mem[wp] <= bus.fifo_din;
        wp      <= (wp + 1) % DEPTH;
      end
      if (bus.fifo_rd_en && cnt > 0) begin
        fd_q <= mem[rp];
        rp   <= (rp + 1) % DEPTH;
        fv_q <= 1'b1;
      end else begin
        fv_q <= 1'b0;
      end
      cnt <= cnt + ((bus.fifo_wr_en && cnt < DEPTH) ? 1 : 0)
                 - ((bus.fifo_rd_en && cnt > 0) ? 1 : 0);
    end
  end

  assign bus.fifo_dout  = fd_q;
  assign bus.fifo_valid = fv_q;
  assign bus.fifo_full  = (cnt >= DEPTH);
  assign bus.fifo_empty = (cnt == 0) || force_empty;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] got_d   [8];
  logic              got_sof [8];
  logic              got_eof [8];
  int                nb;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_sym(input logic [DATA_W-1:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_req;
    bus.frame_req = 1'b1;
    tick();
    bus.frame_req = 1'b0;
  endtask

  // Runs until busy drops, capturing output beats; bounded by max_cycles.
  task automatic wait_idle(input int max_cycles);
    nb = 0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (bus.m_valid && nb < 8) begin
        got_d[nb]   = bus.m_data;
        got_sof[nb] = bus.m_sof;
        got_eof[nb] = bus.m_eof;
        nb++;
      end
      if (!busy) break;
    end
    check("idle_reached", busy, 0);
  endtask

  // Safety net: never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [8:0] exp_rd, exp_mv, exp_sof, exp_eof, exp_busy;

  initial begin
    rst_n             = 1'b0;
    clr_err           = 1'b0;
    force_empty       = 1'b0;
    bus.s_valid       = 1'b0;
    bus.s_data        = '0;
    bus.frame_req     = 1'b0;
    bus.fifo_rst_busy = 1'b1;
    repeat (3) @(negedge clk);

    // ---- reset state ----
    check("rst_level",   level, 0);
    check("rst_busy",    busy, 1);
    check("rst_rd_en",   bus.fifo_rd_en, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_err",     err_underflow, 0);

    // ---- release: srst 4 cycles, ready only after rst_busy drops ----
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("init_srst_c%0d", i),    bus.fifo_srst, (i <= 4));
      check($sformatf("init_s_ready_c%0d", i), bus.s_ready,   (i >= 7));
      if (i == 6) bus.fifo_rst_busy = 1'b0;
    end
    check("init_level", level, 0);
    check("init_idle",  busy, 0);

    // ---- basic frame: 0,1,2,3 ----
    for (int k = 0; k < 4; k++) write_sym(DATA_W'(k));
    check("f1_level_full_frame", level, 4);
    pulse_req();
    exp_rd   = 9'b000011110;
    exp_mv   = 9'b001111000;
    exp_sof  = 9'b000001000;
    exp_eof  = 9'b001000000;
    exp_busy = 9'b011111110;
    for (int c = 0; c <= 8; c++) begin
      check($sformatf("f1_rd_en_c%0d", c),   bus.fifo_rd_en, exp_rd[c]);
      check($sformatf("f1_m_valid_c%0d", c), bus.m_valid,    exp_mv[c]);
      check($sformatf("f1_m_sof_c%0d", c),   bus.m_sof,      exp_sof[c]);
      check($sformatf("f1_m_eof_c%0d", c),   bus.m_eof,      exp_eof[c]);
      check($sformatf("f1_busy_c%0d", c),    busy,           exp_busy[c]);
      if (c >= 3 && c <= 6) check($sformatf("f1_m_data_c%0d", c), bus.m_data, c - 3);
      if (c < 8) tick();
    end
    check("f1_level_end", level, 0);

    // ---- request with only 3 symbols buffered ----
    write_sym(2'd3);
    write_sym(2'd2);
    write_sym(2'd1);
    check("f2_level3", level, 3);
    pulse_req();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("f2_wait_rd_en_%0d", i), bus.fifo_rd_en, 0);
      check($sformatf("f2_wait_busy_%0d", i),  busy, 0);
      tick();
    end
    write_sym(2'd0);
    check("f2_level4",       level, 4);
    check("f2_no_read_yet",  bus.fifo_rd_en, 0);
    tick();
    check("f2_read_entered", bus.fifo_rd_en, 1);
    wait_idle(20);
    check("f2_beats",  nb, 4);
    check("f2_d0",     got_d[0], 3);
    check("f2_d1",     got_d[1], 2);
    check("f2_d2",     got_d[2], 1);
    check("f2_d3",     got_d[3], 0);
    check("f2_sof0",   got_sof[0], 1);
    check("f2_sof1",   got_sof[1], 0);
    check("f2_eof2",   got_eof[2], 0);
    check("f2_eof3",   got_eof[3], 1);

    // ---- fill to DEPTH, then read with concurrent writes ----
    for (int i = 0; i < 16; i++) write_sym(DATA_W'(i % 4));
    check("fill_level16",  level, 16);
    check("fill_s_ready0", bus.s_ready, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 2'd2;
    #1;
    check("fill_no_wr_en", bus.fifo_wr_en, 0);
    tick();
    check("fill_level_hold", level, 16);
    pulse_req();
    tick();
    check("cw_r1_rd_en", bus.fifo_rd_en, 1);
    check("cw_r1_level", level, 16);
    check("cw_r1_ready", bus.s_ready, 0);
    tick();
    check("cw_r2_level", level, 15);
    check("cw_r2_wr_en", bus.fifo_wr_en, 1);
    tick();
    check("cw_r3_level",  level, 15);
    check("cw_r3_m_data", bus.m_data, 0);
    check("cw_r3_m_sof",  bus.m_sof, 1);
    tick();
    check("cw_r4_level",  level, 15);
    check("cw_r4_rd_en",  bus.fifo_rd_en, 1);
    check("cw_r4_m_data", bus.m_data, 1);
    bus.s_valid = 1'b0;
    wait_idle(20);
    check("cw_tail_beats", nb, 2);
    check("cw_tail_d0",    got_d[0], 2);
    check("cw_tail_d1",    got_d[1], 3);
    check("cw_tail_eof",   got_eof[1], 1);
    check("cw_level_end",  level, 14);

    // ---- reset in the middle of a READ burst ----
    pulse_req();
    tick();
    tick();
    tick();
    check("mr_pre_m_valid", bus.m_valid, 1);
    check("mr_pre_rd_en",   bus.fifo_rd_en, 1);
    rst_n             = 1'b0;
    bus.fifo_rst_busy = 1'b1;
    #1;
    check("mr_m_valid", bus.m_valid, 0);
    check("mr_rd_en",   bus.fifo_rd_en, 0);
    check("mr_level",   level, 0);
    check("mr_busy",    busy, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("mr_srst_c%0d", i),    bus.fifo_srst, (i <= 4));
      check($sformatf("mr_s_ready_c%0d", i), bus.s_ready,   (i >= 6));
      if (i == 5) bus.fifo_rst_busy = 1'b0;
    end
    check("mr_level_after", level, 0);
    check("mr_idle_after",  busy, 0);
    check("mr_m_valid_after", bus.m_valid, 0);

    // ---- underflow flag: set, hold, set-beats-clear, clear ----
    write_sym(2'd1);
    write_sym(2'd2);
    write_sym(2'd3);
    write_sym(2'd0);
    pulse_req();
    tick();
    check("uf_r1_rd_en", bus.fifo_rd_en, 1);
    check("uf_r1_err",   err_underflow, 0);
    force_empty = 1'b1;
    tick();
    check("uf_set",  err_underflow, 1);
    force_empty = 1'b0;
    tick();
    check("uf_hold", err_underflow, 1);
    force_empty = 1'b1;
    clr_err     = 1'b1;
    tick();
    check("uf_set_wins", err_underflow, 1);
    force_empty = 1'b0;
    clr_err     = 1'b0;
    wait_idle(20);
    check("uf_sticky_idle", err_underflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("uf_cleared", err_underflow, 0);
    tick();
    check("uf_stays_clear", err_underflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/otfs_frame_fifo_ctrl.md
OTFS_FRAME_FIFO_CTRL -- requirements
Module: otfs_frame_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 2: QAM symbol width in bits (4QAM).
REQ-002 SHALL have parameter DEPTH, default 1024: FIFO depth in symbols.
REQ-003 SHALL have parameter FRAME_LEN, default 64: symbols per OTFS frame (M*N).
REQ-004 SHALL have parameter SRST_CYCLES, default 4: length of the FIFO srst pulse.
REQ-005 SHALL have parameter GAP_CYCLES, default 2: idle cycles between frame bursts.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports s_data in DATA_W, s_valid in 1, s_ready out 1: upstream symbol stream.
REQ-009 SHALL have port frame_req  in  1  single-cycle downstream request for one frame.
REQ-010 SHALL have ports m_data out DATA_W, m_valid out 1, m_sof out 1, m_eof out 1: frame output, no backpressure.
REQ-011 SHALL have FIFO-side ports fifo_srst out 1, fifo_din out DATA_W, fifo_wr_en out 1, fifo_rd_en out 1.
REQ-012 SHALL have FIFO-side ports fifo_dout in DATA_W, fifo_full in 1, fifo_empty in 1, fifo_valid in 1, and fifo_rst_busy in 1 (wr_rst_busy OR rd_rst_busy).
REQ-013 SHALL have ports level out $clog2(DEPTH+1), busy out 1, err_underflow out 1, clr_err in 1.

Function
REQ-014 FSM states SHALL be INIT, IDLE, READ, DRAIN, GAP.
REQ-015 INIT: fifo_srst high for SRST_CYCLES cycles, then low; SHALL stay in INIT until fifo_rst_busy==0, then go to IDLE.
REQ-016 s_ready SHALL be combinational: (state!=INIT) && !fifo_full && level<DEPTH.
REQ-017 fifo_wr_en SHALL equal s_valid && s_ready; fifo_din SHALL equal s_data.
REQ-018 level SHALL +1 on write only, -1 on fifo_rd_en only, and stay unchanged when both occur in the same cycle.
REQ-019 A frame_req pulse SHALL set req_pending; requests arriving while req_pending=1 SHALL be absorbed into it, not queued.
REQ-020 IDLE->READ SHALL occur when req_pending && level>=FRAME_LEN; req_pending clears on that transition.
REQ-021 A frame_req in any state other than INIT SHALL set req_pending; one in the same cycle as the IDLE->READ transition SHALL leave req_pending=1.
REQ-022 READ: fifo_rd_en SHALL be high for exactly FRAME_LEN consecutive cycles, counted by a rd_cnt; then go to DRAIN.
REQ-023 DRAIN SHALL wait until the FRAME_LEN-th fifo_valid has been observed, then go to GAP.
REQ-024 GAP SHALL hold for GAP_CYCLES cycles, then go to IDLE.
REQ-025 m_data/m_valid SHALL be fifo_dout/fifo_valid registered once, so the first m_valid is 2 cycles after the first fifo_rd_en.
REQ-026 m_sof SHALL mark output beat 0 and m_eof output beat FRAME_LEN-1, counted by an out_cnt that wraps to 0 after eof.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 fifo_rd_en while fifo_empty SHALL set sticky err_underflow; clr_err SHALL clear it on the next edge; a set in the same cycle as clr_err SHALL win.
REQ-029 Writes SHALL continue during READ/DRAIN/GAP, subject to REQ-016.

Reset
REQ-030 rst_n low SHALL asynchronously force state=INIT, counters=0, level=0, req_pending=0, err_underflow=0, m_*=0, fifo_rd_en=0.
REQ-031 On rst_n release, fifo_srst SHALL be 1 from the first edge for SRST_CYCLES cycles.
REQ-032 Reset mid-frame SHALL abandon the frame; the FIFO is flushed by the INIT srst pulse.

Verification (bench parameters: FRAME_LEN=4, DEPTH=16, SRST_CYCLES=4, GAP_CYCLES=2)
REQ-033 Release rst_n; hold fifo_rst_busy=1 for 6 cycles -> fifo_srst high 4 cycles; s_ready=0 until busy drops; level=0.
REQ-034 Write 0,1,2,3, pulse frame_req -> fifo_rd_en 4 cycles; m_data 0,1,2,3 with m_sof on 0 and m_eof on 3; first m_valid 2 cycles after first rd_en; level=0.
REQ-035 frame_req with level=3 -> no read; write 4th symbol -> READ entered the cycle after level reaches 4.
REQ-036 Write 16 symbols -> s_ready=0 at level=16; during READ with concurrent writes, level constant.
REQ-037 Assert rst_n low in READ beat 2 -> m_valid, fifo_rd_en, level go to 0 immediately; INIT srst pulse follows release.
REQ-038 Force fifo_empty=1 during READ -> err_underflow=1 and held; pulse clr_err -> 0 next cycle.
